div_unit: RTL



---
 rtl/div_unit_pkg.sv | 16 +
 rtl/div_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: FSM encodings, the divide-by-zero
// result and the EX opcodes that drive start/signed_div.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  localparam logic [63:0] DIV_ZERO_RESULT = 64'h0000_0000_0000_0000;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU) producing {remainder, quotient}.
// Optional DIV_FAST_PATH_EN finishes in one cycle when |dividend| < |divisor|.
import div_unit_pkg::*;

module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  div_state_e         state_r, next_state_s;
  logic [WIDTH-1:0]   dividend_r, divisor_r, rem_r, quo_r;
  logic [WIDTH-1:0]   abs1_s, abs2_s, step_rem_s, step_quo_s, fin_rem_s, fin_quo_s;
  logic [WIDTH:0]     partial_s, diff_s;
  logic [CNT_W-1:0]   counter_r;
  logic               q_neg_r, r_neg_r, fast_s, div_zero_s, last_step_s;
  logic [2*WIDTH-1:0] result_r, result_nxt_s;
  logic               ready_r, ready_nxt_s;

  assign abs1_s      = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign abs2_s      = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
  assign div_zero_s  = (opdata2 == {WIDTH{1'b0}});
  assign last_step_s = (counter_r == LAST_STEP);

`ifdef DIV_FAST_PATH_EN
  assign fast_s = !div_zero_s && (abs1_s < abs2_s);
`else
  assign fast_s = 1'b0;
`endif

  assign partial_s = {rem_r, dividend_r[WIDTH-1]};
  assign diff_s    = partial_s - {1'b0, divisor_r};
  assign fin_rem_s = r_neg_r ? -step_rem_s : step_rem_s;
  assign fin_quo_s = q_neg_r ? -step_quo_s : step_quo_s;

  // One restoring step: keep the trial difference only when it did not borrow.
  always_comb begin
    step_rem_s = partial_s[WIDTH-1:0];
    step_quo_s = {quo_r[WIDTH-2:0], 1'b0};
    if (!diff_s[WIDTH]) begin
      step_rem_s = diff_s[WIDTH-1:0];
      step_quo_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      step_rem_s = partial_s[WIDTH-1:0];
      step_quo_s = {quo_r[WIDTH-2:0], 1'b0};
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= DIV_IDLE;
    else     state_r <= next_state_s;
  end

  // Next-state logic; annul overrides everything, including a fresh start.
  always_comb begin
    next_state_s = state_r;
    if (annul) begin
      next_state_s = DIV_IDLE;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (start && (div_zero_s || fast_s)) next_state_s = DIV_DONE;
          else if (start)                      next_state_s = DIV_BUSY;
          else                                 next_state_s = DIV_IDLE;
        end
        DIV_BUSY: begin
          if (last_step_s) next_state_s = DIV_DONE;
          else             next_state_s = DIV_BUSY;
        end
        DIV_DONE: begin
          if (start) next_state_s = DIV_DONE;
          else       next_state_s = DIV_IDLE;
        end
        default: next_state_s = DIV_IDLE;
      endcase
    end
  end

  // Output logic: result only changes on DONE entry and otherwise holds.
  always_comb begin
    result_nxt_s = result_r;
    ready_nxt_s  = (next_state_s == DIV_DONE);
    if (next_state_s == DIV_DONE) begin
      case (state_r)
        DIV_IDLE: begin
          if (div_zero_s) result_nxt_s = (2*WIDTH)'(DIV_ZERO_RESULT);
          else            result_nxt_s = {opdata1, {WIDTH{1'b0}}};
        end
        DIV_BUSY: result_nxt_s = {fin_rem_s, fin_quo_s};
        default:  result_nxt_s = result_r;
      endcase
    end else begin
      result_nxt_s = result_r;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r <= {(2*WIDTH){1'b0}};
      ready_r  <= 1'b0;
    end else begin
      result_r <= result_nxt_s;
      ready_r  <= ready_nxt_s;
    end
  end

  // Operand capture in IDLE and the shifting datapath in BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_r <= {WIDTH{1'b0}};
      divisor_r  <= {WIDTH{1'b0}};
      rem_r      <= {WIDTH{1'b0}};
      quo_r      <= {WIDTH{1'b0}};
      counter_r  <= {CNT_W{1'b0}};
      q_neg_r    <= 1'b0;
      r_neg_r    <= 1'b0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (start && !annul) begin
            dividend_r <= abs1_s;
            divisor_r  <= abs2_s;
            rem_r      <= {WIDTH{1'b0}};
            quo_r      <= {WIDTH{1'b0}};
            counter_r  <= {CNT_W{1'b0}};
            q_neg_r    <= signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
            r_neg_r    <= signed_div & opdata1[WIDTH-1];
          end else begin
            counter_r  <= counter_r;
          end
        end
        DIV_BUSY: begin
          dividend_r <= {dividend_r[WIDTH-2:0], 1'b0};
          rem_r      <= step_rem_s;
          quo_r      <= step_quo_s;
          counter_r  <= counter_r + CNT_W'(1);
        end
        default: counter_r <= counter_r;
      endcase
    end
  end

  assign result = result_r;
  assign ready  = ready_r;

endmodule
